// File: rtl/pe_border_lanes_if.sv
// Bus bundle for pe_border_lanes: control, operand inputs, and the registered outputs forwarded to neighbours.
interface pe_border_lanes_if #(
   parameter int unsigned IWIDTH = 8,
   parameter int unsigned OWIDTH = 16,
   parameter int unsigned LANES  = 2
);
   localparam int unsigned M = IWIDTH - 1;

   logic                      start;
   logic                      clr;
   logic [LANES*IWIDTH-1:0]   ifm;
   logic                      wght_sign;
   logic [M-1:0]              wght_abs;
   logic [LANES*OWIDTH-1:0]   ofm;
   logic                      busy;
   logic                      done;
   logic [LANES*IWIDTH-1:0]   ifm_d;
   logic                      wght_sign_d;
   logic [M-1:0]              wght_abs_d;
   logic [M-1:0]              randW_d;
   logic [LANES*OWIDTH-1:0]   ofm_d;

   modport master (
      output start, clr, ifm, wght_sign, wght_abs, ofm,
      input  busy, done, ifm_d, wght_sign_d, wght_abs_d, randW_d, ofm_d
   );

   modport slave (
      input  start, clr, ifm, wght_sign, wght_abs, ofm,
      output busy, done, ifm_d, wght_sign_d, wght_abs_d, randW_d, ofm_d
   );
endinterface

// File: rtl/pe_border_lanes.sv
// Border PE: stochastic (counter / bit-reversed counter) sign-magnitude MAC over LANES lanes sharing one weight.
// Define PE_BORDER_LANES_SAT_EN to saturate the accumulators instead of wrapping.
module pe_border_lanes #(
   parameter int unsigned IWIDTH = 8,
   parameter int unsigned OWIDTH = 16,
   parameter int unsigned LANES  = 2
) (
   input logic              clk,
   input logic              rst_n,
   pe_border_lanes_if.slave bus
);
   localparam int unsigned M = IWIDTH - 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]              state, state_nxt;
   logic [M-1:0]            cnt, cnt_nxt;
   logic [M-1:0]            rng_w_q, rng_w_nxt;
   logic [LANES*IWIDTH-1:0] ifm_q, ifm_nxt;
   logic                    wsgn_q, wsgn_nxt;
   logic [M-1:0]            wabs_q, wabs_nxt;
   logic [LANES*OWIDTH-1:0] acc_q, acc_nxt;
   logic                    busy_q, busy_nxt;
   logic                    done_q, done_nxt;

   function automatic logic [M-1:0] bitrev(input logic [M-1:0] v);
      logic [M-1:0] r;
      for (int b = 0; b < int'(M); b++) r[b] = v[int'(M) - 1 - b];
      return r;
   endfunction

   // Two's complement to magnitude; -2^M clamps to 2^M-1.
   function automatic logic [M-1:0] mag(input logic [IWIDTH-1:0] v);
      logic [IWIDTH-1:0] a;
      a = v[IWIDTH-1] ? IWIDTH'(~v + IWIDTH'(1)) : v;
      return a[IWIDTH-1] ? {M{1'b1}} : a[M-1:0];
   endfunction

   function automatic logic [OWIDTH-1:0] step(input logic [OWIDTH-1:0] a, input logic dn);
`ifdef PE_BORDER_LANES_SAT_EN
      if (!dn && (a == {1'b0, {(OWIDTH-1){1'b1}}})) return a;
      if (dn && (a == {1'b1, {(OWIDTH-1){1'b0}}}))  return a;
`endif
      return dn ? OWIDTH'(a - OWIDTH'(1)) : OWIDTH'(a + OWIDTH'(1));
   endfunction

   // Next state, datapath update and registered-output values
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rng_w_nxt = '0;
      ifm_nxt   = ifm_q;
      wsgn_nxt  = wsgn_q;
      wabs_nxt  = wabs_q;
      acc_nxt   = acc_q;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      if (bus.clr) begin
         state_nxt = S_IDLE;
         cnt_nxt   = '0;
         acc_nxt   = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  state_nxt = S_RUN;
                  cnt_nxt   = '0;
                  busy_nxt  = 1'b1;
                  ifm_nxt   = bus.ifm;
                  wsgn_nxt  = bus.wght_sign;
                  wabs_nxt  = bus.wght_abs;
                  acc_nxt   = bus.ofm;
               end
            end
            S_RUN: begin
               busy_nxt = 1'b1;
               for (int k = 0; k < int'(LANES); k++) begin
                  if ((cnt < mag(ifm_q[k*IWIDTH +: IWIDTH])) && (bitrev(cnt) < wabs_q))
                     acc_nxt[k*OWIDTH +: OWIDTH] = step(acc_q[k*OWIDTH +: OWIDTH],
                                                        ifm_q[k*IWIDTH + IWIDTH - 1] ^ wsgn_q);
               end
               cnt_nxt = M'(cnt + M'(1));
               if (cnt == {M{1'b1}}) state_nxt = S_DONE;
               else                  rng_w_nxt = bitrev(M'(cnt + M'(1)));
            end
            S_DONE: begin
               state_nxt = S_IDLE;
               done_nxt  = 1'b1;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         rng_w_q <= '0;
         ifm_q   <= '0;
         wsgn_q  <= 1'b0;
         wabs_q  <= '0;
         acc_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         rng_w_q <= rng_w_nxt;
         ifm_q   <= ifm_nxt;
         wsgn_q  <= wsgn_nxt;
         wabs_q  <= wabs_nxt;
         acc_q   <= acc_nxt;
         busy_q  <= busy_nxt;
         done_q  <= done_nxt;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.ifm_d       = ifm_q;
   assign bus.wght_sign_d = wsgn_q;
   assign bus.wght_abs_d  = wabs_q;
   assign bus.randW_d     = rng_w_q;
   assign bus.ofm_d       = acc_q;
endmodule

// File: tb/tb_pe_border_lanes.sv
// Bench for pe_border_lanes: cycle-level reference model plus directed MAC, clear and reset scenarios.
module tb_pe_border_lanes;
   localparam int IW = 8;
   localparam int OW = 16;
   localparam int LN = 2;
   localparam int M  = IW - 1;
   localparam int L  = 1 << M;
   localparam int AMAX = (1 << (OW - 1)) - 1;
   localparam int AMIN = -(1 << (OW - 1));

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pe_border_lanes_if #(.IWIDTH(IW), .OWIDTH(OW), .LANES(LN)) bus ();
   pe_border_lanes #(.IWIDTH(IW), .OWIDTH(OW), .LANES(LN)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int               m_phase;   // 0 idle, 1 accumulating, 2 finishing
   int               m_cnt;
   bit               m_done;
   int               m_acc [LN];
   int               m_iabs[LN];
   int               m_isgn[LN];
   int               m_wsgn, m_wabs;
   logic [LN*IW-1:0] m_ifm;

   function automatic int brev(input int v);
      int r = 0;
      for (int b = 0; b < M; b++) if (((v >> b) & 1) != 0) r |= 1 << (M - 1 - b);
      return r;
   endfunction

   function automatic int fix(input int a);
`ifdef PE_BORDER_LANES_SAT_EN
      if (a > AMAX) return AMAX;
      if (a < AMIN) return AMIN;
`else
      if (a > AMAX) return a - (1 << OW);
      if (a < AMIN) return a + (1 << OW);
`endif
      return a;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0; m_cnt = 0; m_done = 0; m_ifm = '0; m_wsgn = 0; m_wabs = 0;
         for (int k = 0; k < LN; k++) begin m_acc[k] = 0; m_iabs[k] = 0; m_isgn[k] = 0; end
      end else begin
         m_done = 0;
         if (bus.clr) begin
            m_phase = 0; m_cnt = 0;
            for (int k = 0; k < LN; k++) m_acc[k] = 0;
         end else if (m_phase == 0) begin
            if (bus.start) begin
               m_phase = 1; m_cnt = 0; m_ifm = bus.ifm;
               m_wsgn = int'(bus.wght_sign); m_wabs = int'(bus.wght_abs);
               for (int k = 0; k < LN; k++) begin
                  int v;
                  v = int'($signed(bus.ifm[k*IW +: IW]));
                  m_isgn[k] = (v < 0) ? 1 : 0;
                  m_iabs[k] = (v < 0) ? -v : v;
                  if (m_iabs[k] > L - 1) m_iabs[k] = L - 1;
                  m_acc[k] = int'($signed(bus.ofm[k*OW +: OW]));
               end
            end
         end else if (m_phase == 1) begin
            for (int k = 0; k < LN; k++)
               if (m_cnt < m_iabs[k] && brev(m_cnt) < m_wabs)
                  m_acc[k] = fix(m_acc[k] + (((m_isgn[k] ^ m_wsgn) != 0) ? -1 : 1));
            if (m_cnt == L - 1) m_phase = 2;
            else m_cnt++;
         end else begin
            m_phase = 0;
            m_done  = 1;
         end
      end
   end

   // Per-cycle comparison against the model, away from the rising edge
   always @(negedge clk) begin
      if (rst_n) begin
         check("busy", int'(bus.busy), (m_phase != 0) ? 1 : 0);
         check("done", int'(bus.done), int'(m_done));
         check("randW_d", int'(bus.randW_d), (m_phase == 1) ? brev(m_cnt) : 0);
         check("ifm_d", int'(bus.ifm_d), int'(m_ifm));
         check("wght_sign_d", int'(bus.wght_sign_d), m_wsgn);
         check("wght_abs_d", int'(bus.wght_abs_d), m_wabs);
         for (int k = 0; k < LN; k++)
            check("ofm_d", int'($signed(bus.ofm_d[k*OW +: OW])), m_acc[k]);
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic int lane(input int k);
      return int'($signed(bus.ofm_d[k*OW +: OW]));
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, int'(bus.busy), 0);
      check({tag, "_done"}, int'(bus.done), 0);
      check({tag, "_randW"}, int'(bus.randW_d), 0);
      check({tag, "_ifm_d"}, int'(bus.ifm_d), 0);
      check({tag, "_wsgn"}, int'(bus.wght_sign_d), 0);
      check({tag, "_wabs"}, int'(bus.wght_abs_d), 0);
      check({tag, "_ofm0"}, lane(0), 0);
      check({tag, "_ofm1"}, lane(1), 0);
   endtask

   task automatic load(input int i0, input int i1, input int ws, input int wa, input int o0, input int o1);
      bus.ifm       = {IW'(i1), IW'(i0)};
      bus.wght_sign = 1'(ws);
      bus.wght_abs  = M'(wa);
      bus.ofm       = {OW'(o1), OW'(o0)};
   endtask

   // Latency counts rising edges with the start-sampling edge as edge 0
   task automatic run_mac(input int i0, input int i1, input int ws, input int wa,
                          input int o0, input int o1, output int lat);
      @(negedge clk);
      load(i0, i1, ws, wa, o0, o1);
      bus.start = 1'b1;
      lat = -1;
      for (int n = 0; n < L + 20; n++) begin
         @(posedge clk); #1;
         if (n == 0) begin
            bus.start = 1'b0;
            bus.ifm   = (LN*IW)'($urandom);
            bus.ofm   = (LN*OW)'($urandom);
         end
         if (bus.done) begin lat = n; break; end
      end
   endtask

   task automatic mac_case(input string tag, input int i0, input int i1, input int ws, input int wa,
                           input int o0, input int o1, input int e0, input int e1);
      int lat;
      run_mac(i0, i1, ws, wa, o0, o1, lat);
      check({tag, "_latency"}, lat, L + 1);
      check({tag, "_lane0"}, lane(0), e0);
      check({tag, "_lane1"}, lane(1), e1);
   endtask

   initial begin
      int ndone;
      bus.start = 1'b0; bus.clr = 1'b0;
      load(0, 0, 0, 0, 0, 0);
      #1 check_all_zero("reset");
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;

      mac_case("w64",   127, -127, 0,  64,     0,      0,   64,   -64);
      mac_case("w127",  127,    0, 0, 127,   100,     55,  227,    55);
      mac_case("w0",    127,  127, 0,   0,    77,     -5,   77,    -5);
      mac_case("neg",  -128,    5, 1, 127,     0,      0,  127,    -5);
`ifdef PE_BORDER_LANES_SAT_EN
      mac_case("limit", 127, -127, 0, 127, 32767, -32768, 32767, -32768);
`else
      mac_case("limit", 127, -127, 0, 127, 32767, -32768, -32642, 32641);
`endif

      // Abort with clr on edge 50 of a run; no done may follow
      @(negedge clk);
      load(127, -127, 0, 127, 1234, -1234);
      bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (49) @(posedge clk);
      @(negedge clk) bus.clr = 1'b1;
      @(posedge clk); #1;
      check("clr_busy", int'(bus.busy), 0);
      check("clr_ofm0", lane(0), 0);
      check("clr_ofm1", lane(1), 0);
      bus.clr = 1'b0;
      ndone = 0;
      repeat (L + 5) begin @(posedge clk); #1; if (bus.done) ndone++; end
      check("clr_no_done", ndone, 0);

      // clr wins over start
      @(negedge clk); load(100, 100, 0, 100, 9, 9); bus.clr = 1'b1; bus.start = 1'b1;
      @(posedge clk); #1;
      check("clr_prio_busy", int'(bus.busy), 0);
      check("clr_prio_ofm0", lane(0), 0);
      bus.clr = 1'b0; bus.start = 1'b0;

      // start held through RUN and DONE yields a single completion
      @(negedge clk); load(50, -20, 0, 90, 10, 10); bus.start = 1'b1;
      ndone = 0;
      for (int n = 0; n <= L + 1; n++) begin @(posedge clk); #1; if (bus.done) ndone++; end
      bus.start = 1'b0;
      repeat (L + 5) begin @(posedge clk); #1; if (bus.done) ndone++; end
      check("held_start_dones", ndone, 1);
      check("held_start_idle", int'(bus.busy), 0);

      // Asynchronous reset in the middle of a run
      @(negedge clk); load(127, -127, 1, 127, 300, -300); bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (40) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("midrst");
      ndone = 0;
      repeat (3) begin @(posedge clk); #1; if (bus.done) ndone++; end
      check("midrst_no_done", ndone, 0);
      @(negedge clk); #2 rst_n = 1'b1;
      mac_case("after_rst", 127, 0, 0, 127, 100, 55, 227, 55);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pe_border_lanes.md
PE_BORDER_LANES -- requirements
Module: pe_border_lanes

Interface
REQ-001 SHALL have parameter: IWIDTH, 8, input word width incl. sign; magnitude width M=IWIDTH-1; MAC length L=2^M cycles.
REQ-002 SHALL have parameter: OWIDTH, 16, signed partial-sum width per lane.
REQ-003 SHALL have parameter: LANES, 2, number of independent ifm/ofm lanes sharing one weight, range 1..8.
REQ-004 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port: start  in  1  begin MAC when IDLE.
REQ-007 SHALL have port: clr  in  1  synchronous abort to IDLE.
REQ-008 SHALL have port: ifm  in  LANES*IWIDTH  two's-complement inputs, lane k at bits [k*IWIDTH +: IWIDTH].
REQ-009 SHALL have ports: wght_sign  in  1, and wght_abs  in  M; sign-magnitude weight.
REQ-010 SHALL have port: ofm  in  LANES*OWIDTH  incoming signed partial sums, same packing.
REQ-011 SHALL have ports: busy  out  1, and done  out  1; done is a one-cycle pulse.
REQ-012 SHALL have ports: ifm_d  out  LANES*IWIDTH, wght_sign_d  out  1, wght_abs_d  out  M; registered operands forwarded to neighbours.
REQ-013 SHALL have port: randW_d  out  M  current weight-side random value, forwarded to interior PEs.
REQ-014 SHALL have port: ofm_d  out  LANES*OWIDTH  signed accumulated sums.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; busy=1 in RUN and DONE.
REQ-016 SHALL, in IDLE with start=1: capture ifm, wght_sign, wght_abs; load each lane accumulator with ofm; set cnt=0; go to RUN.
REQ-017 SHALL convert ifm to sign plus M-bit magnitude at capture; magnitude of -2^M clamps to 2^M-1.
REQ-018 SHALL, each RUN cycle: rngI=cnt, rngW=bit-reverse(cnt); ibit_k=(rngI<ifm_abs_k); wbit=(rngW<wght_abs); prod_k=ibit_k AND wbit.
REQ-019 SHALL, when prod_k=1, add +1 to lane k accumulator if ifm_sign_k XOR wght_sign=0; otherwise add -1.
REQ-020 SHALL increment cnt each RUN cycle; the cycle with cnt=L-1 applies its update and transitions to DONE.
REQ-021 SHALL, in DONE: assert done for exactly one cycle, then return to IDLE.
REQ-022 SHALL give start-to-done latency of L+1 cycles: start sampled at edge 0, done high after edge L+1.
REQ-023 SHALL ignore start in RUN and DONE; start in the DONE cycle is not queued.
REQ-024 SHALL, on clr=1 in any state: go to IDLE, zero accumulators and cnt, deassert done; clr has priority over start.
REQ-025 SHALL drive ofm_d continuously from the accumulators; value is held in IDLE until the next start or clr.
REQ-026 SHALL drive randW_d from rngW in RUN and 0 otherwise.
REQ-027 SHALL drive ifm_d and wght_*_d from the captured registers, updated only on accepted start.

Reset
REQ-028 SHALL, on rst_n=0: immediately set state=IDLE, cnt=0, all accumulators 0, busy=0, done=0, ifm_d=0, wght_sign_d=0, wght_abs_d=0, randW_d=0, ofm_d=0.
REQ-029 SHALL make a reset during RUN abandon the MAC; no done is produced.

Configuration
REQ-030 SHALL, with PE_BORDER_LANES_SAT_EN defined, saturate each accumulator at +2^(OWIDTH-1)-1 and -2^(OWIDTH-1); once at a limit, further steps in that direction have no effect.
REQ-031 SHALL, without PE_BORDER_LANES_SAT_EN, wrap each accumulator in two's complement modulo 2^OWIDTH.

Verification
REQ-032 SHALL cover: IWIDTH=8, LANES=2, ofm=0, ifm={+127,-127}, w=+64 -> done at cycle 129, ofm_d={+64,-64}.
REQ-033 SHALL cover: ifm=+127, w=+127, ofm=+100 -> ofm_d=+227; ifm=0 or w=0 -> ofm_d equals ofm.
REQ-034 SHALL cover: ifm=-128, w sign=1 abs=127, ofm=0 -> ofm_d=+127.
REQ-035 SHALL cover: ofm=+32767, ifm=+127, w=+127 -> with SAT_EN 32767; without SAT_EN -32642.
REQ-036 SHALL cover: start at cycle 0, clr at cycle 50 -> IDLE at cycle 51, ofm_d=0, no done; start held high throughout RUN -> exactly one done per accepted start.
REQ-037 SHALL cover: rst_n asserted mid-RUN -> all outputs 0 asynchronously; next start completes normally.
